os_generator: RTL

Ordered-set generator that sits directly downstream of the TX LTSSM. It accepts one ordered-set request per handshake (TS1, TS2, SKP, EIOS or logical Idle) with its link, lane, rate and loopback fields, and serialises it into per-lane PIPE symbols at the configured PIPE width. Its output feeds the TX mux that selects between ordered sets and LPIF data. It covers 8b/10b (Gen1/Gen2) symbol encoding only.

---
 rtl/pcie_os_pkg.sv | 77 +++++++
 rtl/os_symbol_rom.sv | 58 +++++
 rtl/os_generator.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pcie_os_pkg.sv
// ----------------------------------------------------------------------------
// pcie_os_pkg
// Shared definitions for the PCIe ordered-set generator (8b/10b, Gen1/Gen2):
// ordered-set type codes, K-code and TS identifier constants, per-type
// lengths, the latched request record and small helper functions.
// No ports (package).
// ----------------------------------------------------------------------------
package pcie_os_pkg;

  // Ordered-set request codes as presented by the TX LTSSM; 101-111 reserved.
  typedef enum logic [2:0] {
    OS_TS1  = 3'b000,
    OS_TS2  = 3'b001,
    OS_SKP  = 3'b010,
    OS_EIOS = 3'b011,
    OS_IDLE = 3'b100
  } os_type_e;

  // 8b/10b control characters.
  localparam logic [7:0] K_COM = 8'hBC;  // K28.5
  localparam logic [7:0] K_PAD = 8'hF7;  // K23.7
  localparam logic [7:0] K_SKP = 8'h1C;  // K28.0
  localparam logic [7:0] K_IDL = 8'h7C;  // K28.3

  // Training-sequence identifiers filling symbols 6-15.
  localparam logic [7:0] TS1_ID = 8'h4A;
  localparam logic [7:0] TS2_ID = 8'h45;

  // Ordered-set lengths in symbols.
  localparam logic [5:0] LEN_TS   = 6'd16;
  localparam logic [5:0] LEN_SKP  = 6'd4;
  localparam logic [5:0] LEN_EIOS = 6'd4;
  localparam logic [5:0] LEN_IDLE = 6'd16;

  // Lane-field mode: only 01 selects sequential numbering, all else is PAD.
  localparam logic [1:0] LANE_SEQ = 2'b01;

  // Request fields captured when an ordered set is accepted.
  typedef struct packed {
    os_type_e   os_type;
    logic [7:0] link;
    logic [1:0] lane_mode;
    logic [2:0] rate;
    logic       loopback;
  } os_req_t;

  // One PIPE symbol: K flag plus byte.
  typedef struct packed {
    logic       k;
    logic [7:0] data;
  } os_sym_t;

  function automatic logic os_type_valid(input logic [2:0] code);
    return code <= 3'd4;
  endfunction

  function automatic logic [5:0] os_length(input os_type_e os_type);
    case (os_type)
      OS_SKP:  return LEN_SKP;
      OS_EIOS: return LEN_EIOS;
      OS_IDLE: return LEN_IDLE;
      default: return LEN_TS;
    endcase
  endfunction

  // Data Rate Identifier: bits [rate:1] set. Bit 1 (2.5 GT/s) is always
  // advertised, which also makes rate 0 behave as rate 1.
  function automatic logic [7:0] rate_id(input logic [2:0] rate);
    logic [7:0] id;
    id = 8'h02;
    for (int i = 2; i < 8; i++) begin
      if (i <= int'(rate)) id[i] = 1'b1;
    end
    return id;
  endfunction

endpackage

// File: rtl/os_symbol_rom.sv
// ----------------------------------------------------------------------------
// os_symbol_rom
// Combinational lookup of one ordered-set symbol from the latched request,
// the lane it is sent on and its position within the ordered set.
//   req_i      latched request (type, link, lane mode, rate, loopback)
//   lane_i     physical lane index, sent as the lane field in sequential mode
//   sym_idx_i  symbol position 0..15 within the ordered set
//   sym_o      {K flag, byte}; positions past the set length return 0
// ----------------------------------------------------------------------------
module os_symbol_rom
  import pcie_os_pkg::*;
#(
  parameter logic [7:0] NFTS = 8'hFF
) (
  input  os_req_t    req_i,
  input  logic [7:0] lane_i,
  input  logic [3:0] sym_idx_i,
  output os_sym_t    sym_o
);

  always_comb begin
    // NOTE: defaulting every output first keeps this block purely
    // combinational; any path that skipped an assignment would infer a latch.
    sym_o = '0;
    case (req_i.os_type)
      OS_TS1, OS_TS2: begin
        case (sym_idx_i)
          4'd0: sym_o = '{k: 1'b1, data: K_COM};
          4'd1: begin
            if (req_i.link == 8'h00) sym_o = '{k: 1'b1, data: K_PAD};
            else                     sym_o = '{k: 1'b0, data: req_i.link};
          end
          4'd2: begin
            if (req_i.lane_mode == LANE_SEQ) sym_o = '{k: 1'b0, data: lane_i};
            else                             sym_o = '{k: 1'b1, data: K_PAD};
          end
          4'd3: sym_o = '{k: 1'b0, data: NFTS};
          4'd4: sym_o = '{k: 1'b0, data: rate_id(req_i.rate)};
          4'd5: sym_o = '{k: 1'b0, data: {5'b0, req_i.loopback, 2'b0}};
          default: begin
            if (req_i.os_type == OS_TS1) sym_o = '{k: 1'b0, data: TS1_ID};
            else                         sym_o = '{k: 1'b0, data: TS2_ID};
          end
        endcase
      end
      OS_SKP: begin
        if (sym_idx_i == 4'd0)     sym_o = '{k: 1'b1, data: K_COM};
        else if (sym_idx_i < 4'd4) sym_o = '{k: 1'b1, data: K_SKP};
      end
      OS_EIOS: begin
        if (sym_idx_i == 4'd0)     sym_o = '{k: 1'b1, data: K_COM};
        else if (sym_idx_i < 4'd4) sym_o = '{k: 1'b1, data: K_IDL};
      end
      default: sym_o = '0;  // logical Idle: D0.0 on every symbol
    endcase
  end

endmodule

// File: rtl/os_generator.sv
// ----------------------------------------------------------------------------
// os_generator
// Serialises one ordered-set request from the TX LTSSM into per-lane PIPE
// symbols, PIPEWIDTH/8 symbols per beat on every lane.
//   Pclk, Reset        clock, synchronous active-high reset
//   OSType             000 TS1, 001 TS2, 010 SKP, 011 EIOS, 100 Idle
//   LaneNumber         01 sequential lane numbers, otherwise PAD
//   LinkNumber         8'h00 sends PAD, otherwise the link number
//   Rate               highest supported generation (Rate ID field)
//   Loopback           Training Control bit 2
//   OSGeneratorStart   request strobe, honoured only in IDLE
//   OSGeneratorBusy    high on every beat of an ordered set
//   OSGeneratorFinish  one-cycle pulse on the last beat
//   TxData/TxDataK     lane i in [i*MAXPIPEWIDTH +: MAXPIPEWIDTH], symbol 0
//                      in the low byte; unused upper bytes driven 0
//   TxDataValid        high on every beat carrying symbols
// All outputs are registered: the first beat appears the cycle after Start.
// ----------------------------------------------------------------------------
module os_generator
  import pcie_os_pkg::*;
#(
  parameter int         MAXPIPEWIDTH = 32,
  parameter int         PIPEWIDTH    = 8,
  parameter int         LANESNUMBER  = 16,
  parameter logic [7:0] NFTS         = 8'hFF
) (
  input  logic                                  Pclk,
  input  logic                                  Reset,
  input  logic [2:0]                            OSType,
  input  logic [1:0]                            LaneNumber,
  input  logic [7:0]                            LinkNumber,
  input  logic [2:0]                            Rate,
  input  logic                                  Loopback,
  input  logic                                  OSGeneratorStart,
  output logic                                  OSGeneratorBusy,
  output logic                                  OSGeneratorFinish,
  output logic [MAXPIPEWIDTH*LANESNUMBER-1:0]   TxData,
  output logic [MAXPIPEWIDTH/8*LANESNUMBER-1:0] TxDataK,
  output logic                                  TxDataValid
);

  localparam int         SYMS     = PIPEWIDTH / 8;     // symbols per beat
  localparam int         MAX_SYMS = MAXPIPEWIDTH / 8;  // symbol slots per lane
  localparam logic [5:0] STEP     = 6'(SYMS);

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_e;

  state_e     state_q;
  os_req_t    req_q;
  logic [5:0] idx_q;  // first symbol of the beat currently on the outputs

  os_req_t    req_in;
  os_req_t    rom_req;
  logic [5:0] rom_idx;
  logic       last_beat;
  logic       finish_d;
  logic [MAXPIPEWIDTH*LANESNUMBER-1:0]   tx_d;
  logic [MAXPIPEWIDTH/8*LANESNUMBER-1:0] txk_d;

  assign req_in = '{
    os_type:   os_type_e'(OSType),
    link:      LinkNumber,
    lane_mode: LaneNumber,
    rate:      Rate,
    loopback:  Loopback
  };

  // Because outputs are registered, the ROM always looks one beat ahead: in
  // IDLE it encodes beat 0 straight from the request inputs so the first beat
  // lands the cycle after Start; in SEND it encodes the beat after idx_q from
  // the latched fields, so input changes mid-set never leak through.
  always_comb begin
    if (state_q == ST_IDLE) begin
      rom_req = req_in;
      rom_idx = '0;
    end else begin
      rom_req = req_q;
      rom_idx = idx_q + STEP;
    end
  end

  assign finish_d  = (rom_idx + STEP) == os_length(rom_req.os_type);
  assign last_beat = (idx_q + STEP) == os_length(req_q.os_type);

  for (genvar l = 0; l < LANESNUMBER; l++) begin : g_lane
    for (genvar s = 0; s < MAX_SYMS; s++) begin : g_sym
      if (s < SYMS) begin : g_active
        os_sym_t sym;

        os_symbol_rom #(
          .NFTS(NFTS)
        ) u_rom (
          .req_i    (rom_req),
          .lane_i   (8'(l)),
          .sym_idx_i(rom_idx[3:0] + 4'(s)),
          .sym_o    (sym)
        );

        assign tx_d[l*MAXPIPEWIDTH + s*8 +: 8] = sym.data;
        assign txk_d[l*MAX_SYMS + s]           = sym.k;
      end else begin : g_unused
        assign tx_d[l*MAXPIPEWIDTH + s*8 +: 8] = 8'h00;
        assign txk_d[l*MAX_SYMS + s]           = 1'b0;
      end
    end
  end

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register samples pre-edge values, independent of statement order.
  always_ff @(posedge Pclk) begin
    if (Reset) begin
      state_q           <= ST_IDLE;
      req_q             <= '0;
      idx_q             <= '0;
      OSGeneratorBusy   <= 1'b0;
      OSGeneratorFinish <= 1'b0;
      TxDataValid       <= 1'b0;
      TxData            <= '0;
      TxDataK           <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (OSGeneratorStart && os_type_valid(OSType)) begin
            state_q           <= ST_SEND;
            req_q             <= req_in;
            idx_q             <= '0;
            OSGeneratorBusy   <= 1'b1;
            OSGeneratorFinish <= finish_d;
            TxDataValid       <= 1'b1;
            TxData            <= tx_d;
            TxDataK           <= txk_d;
          end else begin
            OSGeneratorBusy   <= 1'b0;
            OSGeneratorFinish <= 1'b0;
            TxDataValid       <= 1'b0;
            TxData            <= '0;
            TxDataK           <= '0;
          end
        end
        ST_SEND: begin
          if (last_beat) begin
            // Outputs drop for one cycle; Start is looked at again next edge.
            state_q           <= ST_IDLE;
            idx_q             <= '0;
            OSGeneratorBusy   <= 1'b0;
            OSGeneratorFinish <= 1'b0;
            TxDataValid       <= 1'b0;
            TxData            <= '0;
            TxDataK           <= '0;
          end else begin
            idx_q             <= rom_idx;
            OSGeneratorBusy   <= 1'b1;
            OSGeneratorFinish <= finish_d;
            TxDataValid       <= 1'b1;
            TxData            <= tx_d;
            TxDataK           <= txk_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
